// File: rtl/vm_credit_accumulator.sv
// Vending-machine credit accumulator: sums coin pulses, settles purchases against the
// running balance and pays change back one coin per clock in a RETURN state.
module vm_credit_accumulator (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] moneyin_pulse,
    input  logic       buy_req,
    input  logic [6:0] price,
    input  logic       ret_req,
    output logic [6:0] balance,
    output logic       coin_reject,
    output logic       buy_ok,
    output logic       buy_fail,
    output logic [3:0] change_out,
    output logic       ret_done,
    output logic       busy
);

    typedef enum logic {StIdle, StReturn} state_t;

    localparam logic [7:0] MaxCredit = 8'd99;

    state_t     state_q, state_d;
    logic [6:0] balance_q, balance_d;
    logic       coin_reject_q, coin_reject_d;
    logic       buy_ok_q, buy_ok_d;
    logic       buy_fail_q, buy_fail_d;
    logic [3:0] change_q, change_d;
    logic       ret_done_q, ret_done_d;

    logic [6:0] coin_sum;
    logic       coin_any;
    logic [6:0] bal_after_buy;
    logic [7:0] bal_with_coins;

    // Coin weights in 100-won units: 1, 5, 10, 50.
    always_comb begin
        coin_sum = 7'd0;
        if (moneyin_pulse[0]) coin_sum = coin_sum + 7'd1;
        if (moneyin_pulse[1]) coin_sum = coin_sum + 7'd5;
        if (moneyin_pulse[2]) coin_sum = coin_sum + 7'd10;
        if (moneyin_pulse[3]) coin_sum = coin_sum + 7'd50;
    end

    assign coin_any = |moneyin_pulse;

    always_comb begin
        state_d        = state_q;
        balance_d      = balance_q;
        coin_reject_d  = 1'b0;
        buy_ok_d       = 1'b0;
        buy_fail_d     = 1'b0;
        change_d       = 4'b0000;
        ret_done_d     = 1'b0;
        bal_after_buy  = balance_q;
        bal_with_coins = 8'd0;

        case (state_q)
            StIdle: begin
                if (ret_req) begin
                    // Return wins: anything else arriving this cycle is refused.
                    state_d       = StReturn;
                    buy_fail_d    = buy_req;
                    coin_reject_d = coin_any;
                end else begin
                    // Purchase is judged on the pre-insertion balance.
                    if (buy_req) begin
                        if (price <= balance_q) begin
                            bal_after_buy = balance_q - price;
                            buy_ok_d      = 1'b1;
                        end else begin
                            buy_fail_d = 1'b1;
                        end
                    end
                    bal_with_coins = {1'b0, bal_after_buy} + {1'b0, coin_sum};
                    if (coin_any && (bal_with_coins > MaxCredit)) begin
                        coin_reject_d = 1'b1;
                        balance_d     = bal_after_buy;
                    end else begin
                        balance_d = bal_with_coins[6:0];
                    end
                end
            end

            StReturn: begin
                coin_reject_d = coin_any;
                buy_fail_d    = buy_req;
                if (balance_q == 7'd0) begin
                    ret_done_d = 1'b1;
                    state_d    = StIdle;
                end else if (balance_q >= 7'd50) begin
                    change_d  = 4'b1000;
                    balance_d = balance_q - 7'd50;
                end else if (balance_q >= 7'd10) begin
                    change_d  = 4'b0100;
                    balance_d = balance_q - 7'd10;
                end else if (balance_q >= 7'd5) begin
                    change_d  = 4'b0010;
                    balance_d = balance_q - 7'd5;
                end else begin
                    change_d  = 4'b0001;
                    balance_d = balance_q - 7'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            balance_q     <= 7'd0;
            coin_reject_q <= 1'b0;
            buy_ok_q      <= 1'b0;
            buy_fail_q    <= 1'b0;
            change_q      <= 4'b0000;
            ret_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            coin_reject_q <= coin_reject_d;
            buy_ok_q      <= buy_ok_d;
            buy_fail_q    <= buy_fail_d;
            change_q      <= change_d;
            ret_done_q    <= ret_done_d;
        end
    end

    assign balance     = balance_q;
    assign coin_reject = coin_reject_q;
    assign buy_ok      = buy_ok_q;
    assign buy_fail    = buy_fail_q;
    assign change_out  = change_q;
    assign ret_done    = ret_done_q;
    assign busy        = (state_q == StReturn);

endmodule

// File: tb/tb_vm_credit_accumulator.sv
// Directed bench for vm_credit_accumulator with hand-computed expectations.
module tb_vm_credit_accumulator;

    logic       clk;
    logic       reset_n;
    logic [3:0] moneyin_pulse;
    logic       buy_req;
    logic [6:0] price;
    logic       ret_req;
    logic [6:0] balance;
    logic       coin_reject;
    logic       buy_ok;
    logic       buy_fail;
    logic [3:0] change_out;
    logic       ret_done;
    logic       busy;

    int tests;
    int failed;

    vm_credit_accumulator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .moneyin_pulse(moneyin_pulse),
        .buy_req      (buy_req),
        .price        (price),
        .ret_req      (ret_req),
        .balance      (balance),
        .coin_reject  (coin_reject),
        .buy_ok       (buy_ok),
        .buy_fail     (buy_fail),
        .change_out   (change_out),
        .ret_done     (ret_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, sample 1 unit after the edge, then idle the inputs.
    task automatic step(input logic [3:0] m, input logic b, input logic [6:0] p,
                        input logic r);
        moneyin_pulse = m;
        buy_req       = b;
        price         = p;
        ret_req       = r;
        @(posedge clk);
        #1;
        moneyin_pulse = 4'b0000;
        buy_req       = 1'b0;
        price         = 7'd0;
        ret_req       = 1'b0;
    endtask

    task automatic check_flags(input string tag, input int cr, input int ok, input int bf,
                               input int rd);
        check({tag, ".coin_reject"}, int'(coin_reject), cr);
        check({tag, ".buy_ok"}, int'(buy_ok), ok);
        check({tag, ".buy_fail"}, int'(buy_fail), bf);
        check({tag, ".ret_done"}, int'(ret_done), rd);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset_n = 1'b0;
        moneyin_pulse = 4'b0000;
        buy_req = 1'b0;
        price = 7'd0;
        ret_req = 1'b0;

        #12;
        check("rst.balance", int'(balance), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.change", int'(change_out), 0);
        check_flags("rst", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // First edge after reset is live; 5 then 15.
        step(4'b0010, 1'b0, 7'd0, 1'b0);
        check("ins500.balance", int'(balance), 5);
        check("ins500.coin_reject", int'(coin_reject), 0);
        step(4'b0100, 1'b0, 7'd0, 1'b0);
        check("ins1000.balance", int'(balance), 15);
        check("ins1000.coin_reject", int'(coin_reject), 0);

        // Purchases: 15-12=3, then 4 refused, then price 0 accepted.
        step(4'b0000, 1'b1, 7'd12, 1'b0);
        check("buy12.balance", int'(balance), 3);
        check_flags("buy12", 0, 1, 0, 0);
        step(4'b0000, 1'b1, 7'd4, 1'b0);
        check("buy4.balance", int'(balance), 3);
        check_flags("buy4", 0, 0, 1, 0);
        step(4'b0000, 1'b1, 7'd0, 1'b0);
        check("buy0.balance", int'(balance), 3);
        check_flags("buy0", 0, 1, 0, 0);
        step(4'b0000, 1'b0, 7'd0, 1'b0);
        check("idle.buy_ok_pulse", int'(buy_ok), 0);

        // Coin + buy together: 3-3+10=10; then price 11 > old 10 fails, coins still land.
        step(4'b0100, 1'b1, 7'd3, 1'b0);
        check("cobuy.balance", int'(balance), 10);
        check_flags("cobuy", 0, 1, 0, 0);
        step(4'b0010, 1'b1, 7'd11, 1'b0);
        check("cobuyfail.balance", int'(balance), 15);
        check_flags("cobuyfail", 0, 0, 1, 0);

        // Fill to 95, then overflow rejects.
        step(4'b1000, 1'b0, 7'd0, 1'b0);
        check("fill65.balance", int'(balance), 65);
        step(4'b0100, 1'b0, 7'd0, 1'b0);
        step(4'b0100, 1'b0, 7'd0, 1'b0);
        step(4'b0100, 1'b0, 7'd0, 1'b0);
        check("fill95.balance", int'(balance), 95);
        step(4'b0010, 1'b0, 7'd0, 1'b0);
        check("over95.balance", int'(balance), 95);
        check("over95.coin_reject", int'(coin_reject), 1);
        // 95-5+50=140 rejected while the buy still goes through.
        step(4'b1000, 1'b1, 7'd5, 1'b0);
        check("overbuy.balance", int'(balance), 90);
        check_flags("overbuy", 1, 1, 0, 0);
        // 90-1+10 = 99 exactly: accepted.
        step(4'b0100, 1'b1, 7'd1, 1'b0);
        check("edge99.balance", int'(balance), 99);
        check_flags("edge99", 0, 1, 0, 0);

        // 49 + (1+10) = 60.
        step(4'b0000, 1'b1, 7'd50, 1'b0);
        check("to49.balance", int'(balance), 49);
        step(4'b0101, 1'b0, 7'd0, 1'b0);
        check("sum11.balance", int'(balance), 60);
        check("sum11.coin_reject", int'(coin_reject), 0);
        step(4'b0000, 1'b1, 7'd44, 1'b0);
        check("to16.balance", int'(balance), 16);

        // Return 16: 10, 5, 1, then ret_done.
        step(4'b0000, 1'b0, 7'd0, 1'b1);
        check("ret0.busy", int'(busy), 1);
        check("ret0.change", int'(change_out), 0);
        check("ret0.balance", int'(balance), 16);
        step(4'b0000, 1'b0, 7'd0, 1'b0);
        check("ret1.change", int'(change_out), 4'b0100);
        check("ret1.balance", int'(balance), 6);
        check("ret1.busy", int'(busy), 1);
        // Inputs during RETURN are refused/ignored; price 0 would succeed in IDLE.
        step(4'b0001, 1'b1, 7'd0, 1'b1);
        check("ret2.change", int'(change_out), 4'b0010);
        check("ret2.balance", int'(balance), 1);
        check_flags("ret2", 1, 0, 1, 0);
        step(4'b0000, 1'b0, 7'd0, 1'b0);
        check("ret3.change", int'(change_out), 4'b0001);
        check("ret3.balance", int'(balance), 0);
        check("ret3.busy", int'(busy), 1);
        step(4'b0000, 1'b0, 7'd0, 1'b0);
        check("ret4.ret_done", int'(ret_done), 1);
        check("ret4.busy", int'(busy), 0);
        check("ret4.change", int'(change_out), 0);
        step(4'b0000, 1'b0, 7'd0, 1'b0);
        check("ret5.ret_done_pulse", int'(ret_done), 0);

        // Return at zero balance: ret_done on the second edge.
        step(4'b0000, 1'b0, 7'd0, 1'b1);
        check("zret0.busy", int'(busy), 1);
        check("zret0.ret_done", int'(ret_done), 0);
        step(4'b0000, 1'b0, 7'd0, 1'b0);
        check("zret1.ret_done", int'(ret_done), 1);
        check("zret1.busy", int'(busy), 0);

        // Build 7, then ret+buy+coin together.
        step(4'b0011, 1'b0, 7'd0, 1'b0);
        step(4'b0001, 1'b0, 7'd0, 1'b0);
        check("to7.balance", int'(balance), 7);
        step(4'b0001, 1'b1, 7'd1, 1'b1);
        check("prio.busy", int'(busy), 1);
        check("prio.balance", int'(balance), 7);
        check_flags("prio", 1, 0, 1, 0);

        // Asynchronous reset mid-RETURN.
        #3;
        reset_n = 1'b0;
        #1;
        check("arst.balance", int'(balance), 0);
        check("arst.busy", int'(busy), 0);
        check("arst.change", int'(change_out), 0);
        check_flags("arst", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b0001, 1'b0, 7'd0, 1'b0);
        check("post.balance", int'(balance), 1);
        check("post.busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
